mesh_port_arbiter: RTL and testbench
====================================

Name: mesh_port_arbiter

Overview:
- Packet-level round-robin arbiter for one 34-bit mesh_tile output link, shared among the 8 directional inputs plus the local injector.
- One instance per output direction inside mesh_tile; instances are independent.
- Holds a grant for a whole packet (head to tail), registers the winning flit onto the link, and releases a stalled owner via an idle watchdog.
- Suppresses new grants while the boot controller holds the mesh in boot mode.

Parameters:
- NUM_REQ, 9, number of requesters: 0=N, 1=S, 2=E, 3=W, 4=NE, 5=NW, 6=SE, 7=SW, 8=local.
- FLIT_W, 34, flit width. Bit [FLIT_W-1] = valid, bit [FLIT_W-2] = tail, remaining bits = payload.
- MAX_IDLE, 16, cycles a locked owner may present no valid flit before forced release (1..255).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- boot_mode  in  1  1 = boot in progress; no new grants.
- req_flit  in  NUM_REQ*FLIT_W  packed input flits; requester i occupies [i*FLIT_W +: FLIT_W].
- req_ready  out  NUM_REQ  one-hot (or zero); flit i is consumed when req_flit valid_i and req_ready[i] are both 1.
- out_flit  out  FLIT_W  registered link flit; bit [FLIT_W-1] is the valid bit.
- out_ready  in  1  downstream accepts out_flit this cycle.
- grant_valid  out  1  1 while a packet lock is held (LOCKED state).
- grant_idx  out  $clog2(NUM_REQ)  current owner; 0 when grant_valid = 0.
- lock_timeout  out  1  one-cycle pulse on watchdog release.

Behaviour:
- Reset (rst=1 at a clock edge): out_flit=0, state=IDLE, rr_ptr=0, idle_cnt=0, grant_valid=0, grant_idx=0, lock_timeout=0. req_ready is combinational and is forced to 0 while rst=1.
- Reset mid-packet: the in-flight packet is dropped and the output register is cleared. The next grant search starts from requester 0.
- can_load = ~out_flit[FLIT_W-1] | out_ready. The output register loads only when can_load=1.
  - If out_flit is valid and out_ready=1 and nothing new loads, out_flit clears to 0.
  - If out_ready=0, out_flit holds unchanged.
- Latency: a flit consumed at edge N appears on out_flit after edge N, i.e. 1 cycle. Throughput is 1 flit/cycle when out_ready is held at 1.
- FSM:
  - IDLE:
    - If boot_mode=0, can_load=1 and any input valid: the winner is the first valid requester searching rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
    - req_ready[winner]=1 and the head flit is consumed in the same cycle.
    - If the head flit is a tail (single-flit packet): stay IDLE and set rr_ptr = winner+1 mod NUM_REQ.
    - Otherwise go to LOCKED with owner=winner and idle_cnt=0.
    - In all other IDLE cases, req_ready=0.
  - LOCKED:
    - req_ready[owner]=can_load; all other bits are 0. boot_mode is ignored, so a packet in progress always completes.
    - Consumed tail flit -> IDLE, rr_ptr = owner+1 mod NUM_REQ.
    - Consumed non-tail flit -> idle_cnt=0.
    - Owner not valid -> idle_cnt increments.
    - Back-pressure (owner valid, can_load=0) -> idle_cnt holds. A stalled link is not a stalled owner.
    - When idle_cnt reaches MAX_IDLE-1 and the owner is still not valid: go to IDLE, rr_ptr = owner+1, and lock_timeout=1 for exactly the next cycle. No tail is synthesized.
- grant_valid and grant_idx are registered and reflect the state after each edge.
- No combinational path from req_flit to out_flit. The only combinational path from out_ready is to req_ready.
- Arbitration is fair: with all requesters continuously valid, each wins once per NUM_REQ packets.

Test Plan:
- Single-flit packet: req 8 presents 34'h3_0000_00AB (valid=1, tail=1), out_ready=1 -> req_ready=9'h100 in the same cycle; out_flit=34'h3_0000_00AB one cycle later, then 0; grant_valid stays 0; rr_ptr=0.
- Multi-flit lock: req 2 sends head 34'h2_0000_0001, body 34'h2_0000_0002, tail 34'h3_0000_0003 while req 0 is continuously valid -> req 0 is not granted until req 2's tail is consumed; out_flit shows the three flits in consecutive cycles; grant_idx=2 during the packet.
- Round-robin fairness: all 9 inputs send single-flit packets continuously -> grant order 0,1,...,8,0 with no repeats within 9 grants.
- Back-pressure: lock on req 5, out_ready=0 for 4 cycles -> out_flit holds, req_ready=0, no timeout; packet resumes losslessly when out_ready returns to 1.
- Watchdog: req 1 sends a non-tail head then drops valid with MAX_IDLE=16 -> lock_timeout pulses exactly once, 16 cycles later; grant_valid=0; the next grant search starts at req 2.
- Boot and reset: boot_mode=1 with all inputs valid -> req_ready=0 and out_flit=0 for the whole interval. Separately, assert rst mid-packet on req 3 -> next cycle out_flit=0, grant_valid=0, rr_ptr=0.

Source files
------------

// File: rtl/mesh_port_arbiter.sv
// Packet-level round-robin arbiter for one mesh_tile output link.
// Locks a requester from head to tail and registers the winning flit.
module mesh_port_arbiter #(
   parameter int NUM_REQ  = 9,
   parameter int FLIT_W   = 34,
   parameter int MAX_IDLE = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        boot_mode,
   input  logic [NUM_REQ*FLIT_W-1:0]   req_flit,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic [FLIT_W-1:0]           out_flit,
   input  logic                        out_ready,
   output logic                        grant_valid,
   output logic [$clog2(NUM_REQ)-1:0]  grant_idx,
   output logic                        lock_timeout
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] IDLE_LAST =
      CNT_W'(MAX_IDLE - 1);

   typedef enum logic {
      S_IDLE,
      S_LOCKED
   } state_e;

   state_e             state_q, state_d;
   logic [FLIT_W-1:0]  out_flit_q, out_flit_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic               grant_valid_q, grant_valid_d;
   logic               lock_timeout_q, lock_timeout_d;
   logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;

   logic [FLIT_W-1:0]  in_flit [NUM_REQ];
   logic [NUM_REQ-1:0] in_valid;
   logic [NUM_REQ-1:0] in_tail;

   logic               can_load;
   logic               arb_found;
   logic [IDX_W-1:0]   arb_idx;
   logic [IDX_W-1:0]   arb_cand;
   logic [IDX_W-1:0]   sel_idx;
   logic               consume;
   logic [NUM_REQ-1:0] ready_c;

   // Index base+off wrapped into 0..NUM_REQ-1 (base always in range).
   function automatic logic [IDX_W-1:0] wrap_add(
      input logic [IDX_W-1:0] base,
      input int unsigned      off
   );
      int unsigned s;
      s = 32'(base) + off;
      if (s >= NUM_REQ) begin
         s = s - NUM_REQ;
      end
      return s[IDX_W-1:0];
   endfunction

   // Split the packed input bus into per-requester flits and flags.
   always_comb begin
      in_valid = '0;
      in_tail  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         in_flit[i]  = req_flit[i*FLIT_W +: FLIT_W];
         in_valid[i] = in_flit[i][FLIT_W-1];
         in_tail[i]  = in_flit[i][FLIT_W-2];
      end
   end

   // The output register is free when empty or being drained.
   always_comb begin
      can_load = ~out_flit_q[FLIT_W-1] | out_ready;
   end

   // First valid requester at or after rr_ptr, wrapping around.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      arb_cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         arb_cand = wrap_add(rr_ptr_q, k);
         if (!arb_found && in_valid[arb_cand]) begin
            arb_found = 1'b1;
            arb_idx   = arb_cand;
         end
      end
   end

   // Grant FSM: next state, lock bookkeeping and ready strobes.
   always_comb begin
      state_d        = state_q;
      rr_ptr_d       = rr_ptr_q;
      owner_d        = owner_q;
      grant_valid_d  = grant_valid_q;
      idle_cnt_d     = idle_cnt_q;
      lock_timeout_d = 1'b0;
      ready_c        = '0;
      sel_idx        = '0;
      consume        = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (!boot_mode && can_load && arb_found) begin
               ready_c[arb_idx] = 1'b1;
               sel_idx          = arb_idx;
               consume          = 1'b1;
               if (in_tail[arb_idx]) begin
                  rr_ptr_d = wrap_add(arb_idx, 1);
               end else begin
                  state_d       = S_LOCKED;
                  owner_d       = arb_idx;
                  grant_valid_d = 1'b1;
                  idle_cnt_d    = '0;
               end
            end
         end

         S_LOCKED: begin
            ready_c[owner_q] = can_load;
            sel_idx          = owner_q;
            if (in_valid[owner_q]) begin
               // A stalled link leaves the counter untouched.
               if (can_load) begin
                  consume    = 1'b1;
                  idle_cnt_d = '0;
                  if (in_tail[owner_q]) begin
                     state_d       = S_IDLE;
                     rr_ptr_d      = wrap_add(owner_q, 1);
                     owner_d       = '0;
                     grant_valid_d = 1'b0;
                  end
               end
            end else if (idle_cnt_q == IDLE_LAST) begin
               state_d        = S_IDLE;
               rr_ptr_d       = wrap_add(owner_q, 1);
               owner_d        = '0;
               grant_valid_d  = 1'b0;
               idle_cnt_d     = '0;
               lock_timeout_d = 1'b1;
            end else begin
               idle_cnt_d = idle_cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output register: load the consumed flit, drain, or hold.
   always_comb begin
      out_flit_d = out_flit_q;
      if (can_load) begin
         if (consume) begin
            out_flit_d = in_flit[sel_idx];
         end else begin
            out_flit_d = '0;
         end
      end
   end

   // Ready is never raised while reset is asserted.
   always_comb begin
      req_ready = rst ? '0 : ready_c;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         out_flit_q     <= '0;
         rr_ptr_q       <= '0;
         owner_q        <= '0;
         grant_valid_q  <= 1'b0;
         lock_timeout_q <= 1'b0;
         idle_cnt_q     <= '0;
      end else begin
         state_q        <= state_d;
         out_flit_q     <= out_flit_d;
         rr_ptr_q       <= rr_ptr_d;
         owner_q        <= owner_d;
         grant_valid_q  <= grant_valid_d;
         lock_timeout_q <= lock_timeout_d;
         idle_cnt_q     <= idle_cnt_d;
      end
   end

   assign out_flit     = out_flit_q;
   assign grant_valid  = grant_valid_q;
   assign grant_idx    = owner_q;
   assign lock_timeout = lock_timeout_q;

endmodule

// File: tb/tb_mesh_port_arbiter.sv
// Directed bench for mesh_port_arbiter.
// Checks grants, locking, fairness, stalls, watchdog, boot and reset.
module tb_mesh_port_arbiter;

   localparam int NUM_REQ  = 9;
   localparam int FLIT_W   = 34;
   localparam int MAX_IDLE = 16;
   localparam int IDX_W    = $clog2(NUM_REQ);

   logic                      clk;
   logic                      rst;
   logic                      boot_mode;
   logic [NUM_REQ*FLIT_W-1:0] req_flit;
   logic [NUM_REQ-1:0]        req_ready;
   logic [FLIT_W-1:0]         out_flit;
   logic                      out_ready;
   logic                      grant_valid;
   logic [IDX_W-1:0]          grant_idx;
   logic                      lock_timeout;

   logic [FLIT_W-1:0] fl [NUM_REQ];

   int checks = 0;
   int errors = 0;

   mesh_port_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .FLIT_W   (FLIT_W),
      .MAX_IDLE (MAX_IDLE)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .boot_mode    (boot_mode),
      .req_flit     (req_flit),
      .req_ready    (req_ready),
      .out_flit     (out_flit),
      .out_ready    (out_ready),
      .grant_valid  (grant_valid),
      .grant_idx    (grant_idx),
      .lock_timeout (lock_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      req_flit = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_flit[i*FLIT_W +: FLIT_W] = fl[i];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_all();
      for (int i = 0; i < NUM_REQ; i++) begin
         fl[i] = '0;
      end
   endtask

   task automatic chk(
      input string       tag,
      input logic [63:0] obs,
      input logic [63:0] exp
   );
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   initial begin
      rst       = 1'b1;
      boot_mode = 1'b0;
      out_ready = 1'b1;
      clear_all();
      tick();
      fl[0] = 34'h3_0000_0001;
      settle();
      chk("rst_ready", 64'(req_ready), 64'h0);
      tick();
      chk("rst_out", 64'(out_flit), 64'h0);
      chk("rst_gv", 64'(grant_valid), 64'h0);
      chk("rst_gi", 64'(grant_idx), 64'h0);
      chk("rst_to", 64'(lock_timeout), 64'h0);
      fl[0] = '0;
      rst   = 1'b0;
      tick();

      // single-flit packet from local injector
      fl[8] = 34'h3_0000_00AB;
      settle();
      chk("sf_ready", 64'(req_ready), 64'h100);
      tick();
      chk("sf_out", 64'(out_flit), 64'h3_0000_00AB);
      chk("sf_gv", 64'(grant_valid), 64'h0);
      fl[8] = '0;
      settle();
      chk("sf_ready0", 64'(req_ready), 64'h0);
      tick();
      chk("sf_drain", 64'(out_flit), 64'h0);

      // rr_ptr wrapped to 0: req 0 beats req 1
      fl[0] = 34'h3_0000_0010;
      fl[1] = 34'h3_0000_0011;
      settle();
      chk("rr0_ready", 64'(req_ready), 64'h001);
      tick();
      chk("rr0_out", 64'(out_flit), 64'h3_0000_0010);
      clear_all();
      tick();

      // multi-flit lock on req 2 while req 0 waits
      fl[2] = 34'h2_0000_0001;
      settle();
      chk("mf_head_rdy", 64'(req_ready), 64'h004);
      tick();
      chk("mf_head_out", 64'(out_flit), 64'h2_0000_0001);
      chk("mf_gv", 64'(grant_valid), 64'h1);
      chk("mf_gi", 64'(grant_idx), 64'h2);
      fl[2] = 34'h2_0000_0002;
      fl[0] = 34'h3_0000_0055;
      settle();
      chk("mf_body_rdy", 64'(req_ready), 64'h004);
      tick();
      chk("mf_body_out", 64'(out_flit), 64'h2_0000_0002);
      chk("mf_gi_body", 64'(grant_idx), 64'h2);
      fl[2] = 34'h3_0000_0003;
      settle();
      chk("mf_tail_rdy", 64'(req_ready), 64'h004);
      tick();
      chk("mf_tail_out", 64'(out_flit), 64'h3_0000_0003);
      chk("mf_gv_end", 64'(grant_valid), 64'h0);
      chk("mf_gi_end", 64'(grant_idx), 64'h0);
      fl[2] = '0;
      settle();
      chk("mf_req0_rdy", 64'(req_ready), 64'h001);
      tick();
      chk("mf_req0_out", 64'(out_flit), 64'h3_0000_0055);
      fl[0] = '0;
      tick();
      chk("mf_drain", 64'(out_flit), 64'h0);

      // move rr_ptr to 0 through req 8
      fl[8] = 34'h3_0000_0088;
      tick();
      fl[8] = '0;
      tick();

      // fairness: all requesters continuously valid
      for (int i = 0; i < NUM_REQ; i++) begin
         fl[i] = {2'b11, 32'(i + 'h100)};
      end
      for (int g = 0; g < 10; g++) begin
         settle();
         chk("rr_ready", 64'(req_ready),
             64'(1) << (g % NUM_REQ));
         tick();
         chk("rr_out", 64'(out_flit),
             {30'h0, 2'b11, 32'((g % NUM_REQ) + 'h100)});
      end
      clear_all();
      tick();
      chk("rr_drain", 64'(out_flit), 64'h0);

      // back-pressure on a req 5 packet (rr_ptr = 1)
      fl[5] = 34'h2_0000_0501;
      settle();
      chk("bp_head_rdy", 64'(req_ready), 64'h020);
      tick();
      chk("bp_gi", 64'(grant_idx), 64'h5);
      out_ready = 1'b0;
      fl[5]     = 34'h2_0000_0502;
      for (int c = 0; c < 4; c++) begin
         settle();
         chk("bp_ready0", 64'(req_ready), 64'h0);
         tick();
         chk("bp_hold", 64'(out_flit), 64'h2_0000_0501);
         chk("bp_to", 64'(lock_timeout), 64'h0);
         chk("bp_gv", 64'(grant_valid), 64'h1);
      end
      out_ready = 1'b1;
      settle();
      chk("bp_resume", 64'(req_ready), 64'h020);
      tick();
      chk("bp_body", 64'(out_flit), 64'h2_0000_0502);
      fl[5] = 34'h3_0000_0503;
      tick();
      chk("bp_tail", 64'(out_flit), 64'h3_0000_0503);
      chk("bp_gv_end", 64'(grant_valid), 64'h0);
      fl[5] = '0;
      tick();

      // watchdog on req 1 (rr_ptr = 6 searches 6,7,8,0,1)
      fl[1] = 34'h2_0000_0101;
      settle();
      chk("wd_head_rdy", 64'(req_ready), 64'h002);
      tick();
      chk("wd_gi", 64'(grant_idx), 64'h1);
      fl[1] = '0;
      for (int c = 1; c < MAX_IDLE; c++) begin
         tick();
         chk("wd_wait_to", 64'(lock_timeout), 64'h0);
         chk("wd_wait_gv", 64'(grant_valid), 64'h1);
      end
      tick();
      chk("wd_pulse", 64'(lock_timeout), 64'h1);
      chk("wd_gv", 64'(grant_valid), 64'h0);
      chk("wd_gi0", 64'(grant_idx), 64'h0);
      chk("wd_out", 64'(out_flit), 64'h0);
      fl[0] = 34'h3_0000_0200;
      fl[2] = 34'h3_0000_0202;
      settle();
      chk("wd_next_rdy", 64'(req_ready), 64'h004);
      tick();
      chk("wd_pulse_end", 64'(lock_timeout), 64'h0);
      chk("wd_next_out", 64'(out_flit), 64'h3_0000_0202);
      clear_all();
      tick();

      // boot mode blocks grants (rr_ptr = 3)
      boot_mode = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
         fl[i] = {2'b11, 32'(i + 'h300)};
      end
      for (int c = 0; c < 5; c++) begin
         settle();
         chk("boot_ready", 64'(req_ready), 64'h0);
         tick();
         chk("boot_out", 64'(out_flit), 64'h0);
      end
      boot_mode = 1'b0;
      settle();
      chk("boot_exit", 64'(req_ready), 64'h008);
      clear_all();
      tick();

      // reset in the middle of a req 3 packet
      fl[3] = 34'h2_0000_0301;
      settle();
      chk("rm_head_rdy", 64'(req_ready), 64'h008);
      tick();
      chk("rm_gi", 64'(grant_idx), 64'h3);
      fl[3] = 34'h2_0000_0302;
      tick();
      chk("rm_body", 64'(out_flit), 64'h2_0000_0302);
      rst = 1'b1;
      settle();
      chk("rm_ready0", 64'(req_ready), 64'h0);
      tick();
      chk("rm_out", 64'(out_flit), 64'h0);
      chk("rm_gv", 64'(grant_valid), 64'h0);
      chk("rm_gi0", 64'(grant_idx), 64'h0);
      rst = 1'b0;
      clear_all();
      fl[1] = 34'h3_0000_0401;
      fl[8] = 34'h3_0000_0408;
      settle();
      chk("rm_rr0", 64'(req_ready), 64'h002);
      tick();
      chk("rm_rr0_out", 64'(out_flit), 64'h3_0000_0401);
      clear_all();
      tick();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
